// File: rtl/mil1553_tx_arbiter.sv
// mil1553_tx_arbiter
// Round-robin arbiter in front of the 1553 encoder. Two AXI-Stream sources
// (s0 = UART bridge, s1 = local responder) share one master port. Arbitration
// is per whole message, so words from the two sources are never interleaved.
// A minimum dead time separates messages on the bus. A watchdog releases an
// owner that stops presenting words in the middle of a message.
// The datapath is purely combinational: the owner's word reaches the encoder
// in the same cycle, and the encoder's tready goes straight back to the owner.

module mil1553_tx_arbiter #(
  parameter int clock_speed    = 50000000,
  parameter int gap_us         = 4,
  parameter int timeout_cycles = 2000
) (
  input  logic        aclk,
  input  logic        arst,

  input  logic [15:0] s0_axis_tdata,
  input  logic [7:0]  s0_axis_tuser,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,

  input  logic [15:0] s1_axis_tdata,
  input  logic [7:0]  s1_axis_tuser,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,

  output logic [15:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,

  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  // Dead time between messages, in aclk cycles.
  localparam int GAP_CYCLES = (clock_speed / 1000000) * gap_us;

  // The gap counter only ever holds GAP_CYCLES-1 down to 0, and the watchdog
  // only ever holds 0 up to timeout_cycles-1, so each needs just enough bits
  // for its largest value.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WD_W  = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_LIMIT =
    (timeout_cycles > 0) ? WD_W'(timeout_cycles - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // owner_q: current/last owner, 0 = s0, 1 = s1.
  logic             owner_q, owner_d;
  // ptr_q: source favoured when both request together, 0 = s0, 1 = s1.
  logic             ptr_q, ptr_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             terr_q, terr_d;

  logic             own_valid;
  logic             own_last;
  logic             own_hs;

  // Select the owner's handshake signals that steer the FSM.
  always_comb begin
    own_valid = owner_q ? s1_axis_tvalid : s0_axis_tvalid;
    own_last  = owner_q ? s1_axis_tlast  : s0_axis_tlast;
    own_hs    = (state_q == GRANT) && own_valid && m_axis_tready;
  end

  // State register plus all counters; everything clears on async reset so the
  // decoded outputs return to their idle values immediately.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gap_q   <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: arbitration in IDLE, end-of-message and watchdog in
  // GRANT, dead-time countdown in GAP.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    terr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_d = GRANT;
          owner_d = (s0_axis_tvalid && s1_axis_tvalid) ? ptr_q : s1_axis_tvalid;
          wd_d    = '0;
        end
      end

      GRANT: begin
        if (own_hs) begin
          wd_d = '0;
          if (own_last) begin
            ptr_d = ~owner_q;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end
        end else if (!own_valid) begin
          if (wd_q == WD_LIMIT) begin
            terr_d = 1'b1;
            wd_d   = '0;
            ptr_d  = ~owner_q;
            if (GAP_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: route the owner to the encoder in GRANT, keep everything
  // quiet otherwise.
  always_comb begin
    grant          = 2'b00;
    busy           = (state_q != IDLE);
    timeout_err    = terr_q;
    m_axis_tdata   = '0;
    m_axis_tuser   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;

    if (state_q == GRANT) begin
      if (owner_q) begin
        grant          = 2'b10;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tuser   = s1_axis_tuser;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        s1_axis_tready = m_axis_tready;
      end else begin
        grant          = 2'b01;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tuser   = s0_axis_tuser;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

endmodule

// File: tb/tb_mil1553_tx_arbiter.sv
// tb_mil1553_tx_arbiter
// Two source drivers feed message queues into the arbiter; every issued word is
// also pushed into a per-source expected queue. A monitor process pops and
// compares whenever the encoder side completes a handshake, and tracks the
// message-level rules (round-robin winner, dead-time length, watchdog) from
// the rules themselves. A second instance built with no dead time covers the
// back-to-back case.

module tb_mil1553_tx_arbiter;

  localparam int CLK_HZ = 50000000;
  localparam int GAP_US = 4;
  localparam int TMO    = 2000;
  localparam int G      = (CLK_HZ / 1000000) * GAP_US;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  user;
    logic        last;
    int          idle;
  } word_t;

  logic tb_data_clk = 1'b0;
  always #5 tb_data_clk = ~tb_data_clk;

  logic             arst;
  logic [1:0][15:0] s_tdata;
  logic [1:0][7:0]  s_tuser;
  logic [1:0]       s_tvalid;
  logic [1:0]       s_tlast;
  wire  [1:0]       s_tready;
  wire  [15:0]      m_tdata;
  wire  [7:0]       m_tuser;
  wire              m_tvalid;
  wire              m_tlast;
  logic             m_tready;
  wire  [1:0]       grant;
  wire              busy;
  wire              timeout_err;

  logic [15:0] z_tdata;
  logic        z_tvalid;
  logic        z_tlast;
  wire         z_s0_tready;
  wire         z_s1_tready;
  wire  [15:0] z_m_tdata;
  wire  [7:0]  z_m_tuser;
  wire         z_m_tvalid;
  wire         z_m_tlast;
  wire  [1:0]  z_grant;
  wire         z_busy;
  wire         z_timeout_err;

  mil1553_tx_arbiter #(
    .clock_speed(CLK_HZ), .gap_us(GAP_US), .timeout_cycles(TMO)
  ) u_dut (
    .aclk(tb_data_clk), .arst(arst),
    .s0_axis_tdata(s_tdata[0]), .s0_axis_tuser(s_tuser[0]),
    .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tlast(s_tlast[0]),
    .s0_axis_tready(s_tready[0]),
    .s1_axis_tdata(s_tdata[1]), .s1_axis_tuser(s_tuser[1]),
    .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tlast(s_tlast[1]),
    .s1_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  mil1553_tx_arbiter #(
    .clock_speed(CLK_HZ), .gap_us(0), .timeout_cycles(TMO)
  ) u_dut_nogap (
    .aclk(tb_data_clk), .arst(arst),
    .s0_axis_tdata(z_tdata), .s0_axis_tuser(8'h5A),
    .s0_axis_tvalid(z_tvalid), .s0_axis_tlast(z_tlast),
    .s0_axis_tready(z_s0_tready),
    .s1_axis_tdata(16'h0000), .s1_axis_tuser(8'h00),
    .s1_axis_tvalid(1'b0), .s1_axis_tlast(1'b0),
    .s1_axis_tready(z_s1_tready),
    .m_axis_tdata(z_m_tdata), .m_axis_tuser(z_m_tuser), .m_axis_tvalid(z_m_tvalid),
    .m_axis_tlast(z_m_tlast), .m_axis_tready(1'b1),
    .grant(z_grant), .busy(z_busy), .timeout_err(z_timeout_err)
  );

  word_t  src_q [2][$];
  word_t  exp_q [2][$];
  logic [1:0] hold;
  logic   rand_ready;

  int     tests;
  int     fails;

  longint cyc;
  longint to_at;
  longint gap_idle_at;
  logic   ptr_m;
  int     wd_m;
  logic   arb_pending;
  logic [1:0] arb_exp;
  logic [1:0] prev_grant;
  logic   gap_active;
  int     gap_bad;
  int     spurious_to;
  int     proto_viol;
  int     grant_viol;
  logic   to_seen;

  task automatic checkOutput(input string name, input logic ok,
                             input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input int k, input int nwords, input int max_idle);
    word_t w;
    for (int i = 0; i < nwords; i++) begin
      w.data = 16'($urandom());
      w.user = 8'($urandom());
      w.last = (i == nwords - 1);
      w.idle = (max_idle > 0) ? $urandom_range(0, max_idle) : 0;
      src_q[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  task automatic run_driver(input int k);
    logic hs;
    int   idle_left;
    logic fresh;
    idle_left = 0;
    fresh = 1'b1;
    forever begin
      @(negedge tb_data_clk);
      hs = s_tvalid[k] && s_tready[k];
      @(posedge tb_data_clk);
      #1;
      if (arst) begin
        s_tvalid[k] = 1'b0;
        fresh = 1'b1;
      end else begin
        if (hs && src_q[k].size() > 0) begin
          void'(src_q[k].pop_front());
          fresh = 1'b1;
        end
        if (src_q[k].size() > 0) begin
          if (fresh) begin
            idle_left = src_q[k][0].idle;
            fresh = 1'b0;
          end
          s_tdata[k] = src_q[k][0].data;
          s_tuser[k] = src_q[k][0].user;
          s_tlast[k] = src_q[k][0].last;
          if (idle_left > 0) begin
            idle_left--;
            s_tvalid[k] = 1'b0;
          end else begin
            s_tvalid[k] = !hold[k];
          end
        end else begin
          s_tvalid[k] = 1'b0;
          s_tlast[k]  = 1'b0;
        end
      end
    end
  endtask

  task automatic run_ready();
    forever begin
      @(posedge tb_data_clk);
      #1;
      if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic end_message(input int owner);
    ptr_m       = (owner == 0);
    wd_m        = 0;
    gap_active  = 1'b1;
    gap_idle_at = cyc + 1 + G;
    gap_bad     = 0;
  endtask

  task automatic run_monitor();
    int    owner;
    word_t w;
    forever begin
      @(negedge tb_data_clk);
      cyc++;
      if (arst) begin
        ptr_m = 1'b0; wd_m = 0; arb_pending = 1'b0; gap_active = 1'b0;
        to_at = -1; prev_grant = 2'b00;
      end else begin
        if (cyc == to_at) begin
          checkOutput("timeout_pulse", timeout_err === 1'b1 && grant == 2'b00,
                      {grant, timeout_err}, 3'b001);
          to_seen = 1'b1;
          to_at = -1;
        end else if (timeout_err !== 1'b0) begin
          spurious_to++;
        end

        if (gap_active) begin
          if (cyc < gap_idle_at) begin
            if (!(busy === 1'b1 && grant == 2'b00 && m_tvalid === 1'b0 && s_tready == 2'b00))
              gap_bad++;
          end else begin
            checkOutput("gap_length", gap_bad == 0 && busy === 1'b0, gap_bad, 0);
            gap_active = 1'b0;
          end
        end

        if (arb_pending) begin
          checkOutput("arb_winner", grant == arb_exp, grant, arb_exp);
          arb_pending = 1'b0;
          wd_m = 0;
        end else if (prev_grant == 2'b00 && grant != 2'b00) begin
          grant_viol++;
        end

        if (grant == 2'b00) begin
          if (m_tvalid !== 1'b0 || s_tready != 2'b00) proto_viol++;
          if (busy === 1'b0 && !gap_active && s_tvalid != 2'b00) begin
            arb_pending = 1'b1;
            if (s_tvalid == 2'b11) arb_exp = ptr_m ? 2'b10 : 2'b01;
            else                   arb_exp = s_tvalid;
          end
        end else if (grant != 2'b01 && grant != 2'b10) begin
          proto_viol++;
        end else begin
          owner = grant[1] ? 1 : 0;
          if (s_tready[owner] !== m_tready || s_tready[1 - owner] !== 1'b0 ||
              busy !== 1'b1 || m_tvalid !== s_tvalid[owner])
            proto_viol++;
          if (m_tvalid && m_tready) begin
            wd_m = 0;
            if (exp_q[owner].size() == 0) begin
              checkOutput("word_unexpected", 1'b0, m_tdata, 0);
            end else begin
              w = exp_q[owner].pop_front();
              checkOutput($sformatf("word_src%0d", owner),
                          m_tdata == w.data && m_tuser == w.user && m_tlast == w.last,
                          {7'd0, m_tdata, m_tuser, m_tlast}, {7'd0, w.data, w.user, w.last});
            end
            if (m_tlast) end_message(owner);
          end else if (!s_tvalid[owner]) begin
            wd_m++;
            if (wd_m == TMO) begin
              to_at = cyc + 1;
              end_message(owner);
            end
          end
        end
        prev_grant = grant;
      end
    end
  endtask

  task automatic wait_quiet(input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge tb_data_clk);
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && exp_q[0].size() == 0 &&
          exp_q[1].size() == 0 && busy === 1'b0 && s_tvalid == 2'b00)
        done = 1'b1;
    end
    if (!done) checkOutput("quiet_timeout", 1'b0, busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_grant"}, grant === 2'b00, grant, 0);
    checkOutput({tag, "_busy"}, busy === 1'b0, busy, 0);
    checkOutput({tag, "_timeout_err"}, timeout_err === 1'b0, timeout_err, 0);
    checkOutput({tag, "_m_tvalid"}, m_tvalid === 1'b0, m_tvalid, 0);
    checkOutput({tag, "_s_tready"}, s_tready === 2'b00, s_tready, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge tb_data_clk);
    #2;
    arst = 1'b1;
    #1;
    check_reset_values(tag);
    src_q[0].delete(); src_q[1].delete();
    exp_q[0].delete(); exp_q[1].delete();
    hold = 2'b00;
    repeat (3) @(posedge tb_data_clk);
    #2;
    arst = 1'b0;
  endtask

  task automatic wait_exp_size(input int k, input int sz);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge tb_data_clk);
      if (exp_q[k].size() == sz) ok = 1'b1;
    end
    if (!ok) checkOutput("wait_word_timeout", 1'b0, exp_q[k].size(), sz);
  endtask

  initial begin
    logic [15:0] held_d;
    logic [7:0]  held_u;
    logic        held_l;
    logic        ok;
    int          bad;
    int          mask;

    tests = 0; fails = 0; cyc = 0; to_at = -1; gap_idle_at = 0;
    ptr_m = 1'b0; wd_m = 0; arb_pending = 1'b0; arb_exp = 2'b00; prev_grant = 2'b00;
    gap_active = 1'b0; gap_bad = 0; spurious_to = 0; proto_viol = 0; grant_viol = 0;
    to_seen = 1'b0; hold = 2'b00; rand_ready = 1'b0; m_tready = 1'b1;
    s_tdata = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
    z_tdata = '0; z_tvalid = 1'b0; z_tlast = 1'b0;
    arst = 1'b0;
    #3;
    arst = 1'b1;
    #1;
    check_reset_values("reset");
    repeat (3) @(posedge tb_data_clk);
    #2;
    arst = 1'b0;

    fork
      run_driver(0);
      run_driver(1);
      run_ready();
      run_monitor();
    join_none

    $display("[TB] 3-word message on s0");
    @(negedge tb_data_clk);
    applyStimulus(0, 3, 0);
    wait_quiet(1000);

    $display("[TB] simultaneous requests after reset");
    do_reset("reset_idle");
    @(negedge tb_data_clk);
    applyStimulus(0, 2, 0);
    applyStimulus(1, 2, 0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge tb_data_clk);
      if (grant == 2'b10) ok = 1'b1;
    end
    checkOutput("s1_served_second", ok, grant, 2'b10);
    applyStimulus(0, 2, 0);
    applyStimulus(1, 1, 0);
    wait_quiet(2000);

    $display("[TB] encoder backpressure");
    @(negedge tb_data_clk);
    applyStimulus(0, 3, 0);
    wait_exp_size(0, 2);
    #1;
    m_tready = 1'b0;
    @(negedge tb_data_clk);
    held_d = m_tdata; held_u = m_tuser; held_l = m_tlast;
    bad = 0;
    repeat (500) begin
      @(negedge tb_data_clk);
      if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tuser !== held_u || m_tlast !== held_l)
        bad++;
    end
    checkOutput("backpressure_hold", bad == 0, bad, 0);
    @(posedge tb_data_clk);
    #1;
    m_tready = 1'b1;
    wait_quiet(1000);

    $display("[TB] watchdog release of stalled s1");
    @(negedge tb_data_clk);
    applyStimulus(1, 4, 0);
    wait_exp_size(1, 3);
    hold[1] = 1'b1;
    @(negedge tb_data_clk);
    applyStimulus(0, 2, 0);
    to_seen = 1'b0;
    for (int i = 0; i < TMO + 200 && !to_seen; i++) @(negedge tb_data_clk);
    checkOutput("timeout_seen", to_seen, to_seen, 1);
    src_q[1].delete();
    exp_q[1].delete();
    hold[1] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < G + 20 && !ok; i++) begin
      @(negedge tb_data_clk);
      if (grant != 2'b00) ok = 1'b1;
    end
    checkOutput("after_timeout_grant", grant == 2'b01, grant, 2'b01);
    wait_quiet(1000);

    $display("[TB] reset mid-message");
    @(negedge tb_data_clk);
    applyStimulus(0, 5, 0);
    wait_exp_size(0, 3);
    do_reset("reset_mid");
    @(negedge tb_data_clk);
    applyStimulus(0, 2, 0);
    wait_quiet(1000);

    $display("[TB] randomized traffic");
    rand_ready = 1'b1;
    for (int it = 0; it < 15; it++) begin
      @(negedge tb_data_clk);
      mask = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++)
        if (mask[k]) applyStimulus(k, $urandom_range(1, 4), 2);
      repeat ($urandom_range(0, 250)) @(negedge tb_data_clk);
      if ($urandom_range(0, 1) == 1) applyStimulus($urandom_range(0, 1), $urandom_range(1, 3), 2);
      wait_quiet(3000);
    end
    rand_ready = 1'b0;
    @(posedge tb_data_clk);
    #1;
    m_tready = 1'b1;

    $display("[TB] back-to-back messages with no dead time");
    @(posedge tb_data_clk);
    #1;
    z_tdata = 16'hA001; z_tlast = 1'b0; z_tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge tb_data_clk);
      if (z_s0_tready) ok = 1'b1;
    end
    checkOutput("nogap_first_grant", ok && z_grant == 2'b01, z_grant, 2'b01);
    @(posedge tb_data_clk);
    #1;
    z_tdata = 16'hA002; z_tlast = 1'b1;
    @(negedge tb_data_clk);
    checkOutput("nogap_last_ready", z_s0_tready === 1'b1, z_s0_tready, 1);
    @(posedge tb_data_clk);
    #1;
    z_tdata = 16'hB003; z_tlast = 1'b1;
    @(negedge tb_data_clk);
    checkOutput("nogap_idle", z_grant == 2'b00 && z_busy === 1'b0, {z_grant, z_busy}, 0);
    @(negedge tb_data_clk);
    checkOutput("nogap_regrant", z_grant == 2'b01 && z_m_tdata == 16'hB003,
                {z_grant, z_m_tdata}, {2'b01, 16'hB003});
    @(posedge tb_data_clk);
    #1;
    z_tvalid = 1'b0; z_tlast = 1'b0;
    repeat (4) @(negedge tb_data_clk);

    checkOutput("no_spurious_timeout", spurious_to == 0, spurious_to, 0);
    checkOutput("port_protocol", proto_viol == 0, proto_viol, 0);
    checkOutput("no_unrequested_grant", grant_viol == 0, grant_viol, 0);
    checkOutput("scoreboard_drained", exp_q[0].size() == 0 && exp_q[1].size() == 0,
                exp_q[0].size() + exp_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
